// File: rtl/z180_bus_pkg.sv
// Shared constants and helpers for the Z180 bus strobe conditioning slice.
package z180_bus_pkg;

  localparam int unsigned CNT_W               = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned RD_TICK_EDGE        = 0;
  localparam int unsigned WR_TICK_EDGE        = 1;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      sat_inc = value;
    end else begin
      sat_inc = value + CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/iorq_tick_fsm.sv
// Counts phi falls within one I/O cycle and emits a single qualification tick.
module iorq_tick_fsm
  import z180_bus_pkg::*;
#(
  parameter int unsigned TICK_EDGE = RD_TICK_EDGE
) (
  input  logic hwclk,
  input  logic fsm_rst,
  input  logic phi_ce,
  input  logic iorq_n,
  input  logic dir_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] EDGE_CNT = CNT_W'(TICK_EDGE);

  logic [CNT_W-1:0] cnt_r;
  logic             active_s;

  assign active_s = ~iorq_n & ~dir_n;

  // Count phi falls seen with the strobe asserted; any idle phi fall restarts it.
  always_ff @(posedge hwclk) begin
    if (fsm_rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (phi_ce) begin
      if (active_s) begin
        cnt_r <= sat_inc(cnt_r);
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Mealy output so consumers can capture on the same edge as the phi fall.
  assign tick = phi_ce & active_s & (cnt_r == EDGE_CNT) & ~fsm_rst;

endmodule

// File: rtl/switch_debounce.sv
// Reset push-button conditioning: 2-FF synchroniser plus a level-hold debouncer.
module switch_debounce
  import z180_bus_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic hwclk,
  input  logic reset_n,
  input  logic sw_n,
  output logic cpu_reset_n
);

  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic [DB_W-1:0] db_cnt_r;

  // Bring the asynchronous button into the hwclk domain; idles released.
  always_ff @(posedge hwclk) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= sw_n;
      sync2_r <= sync1_r;
    end
  end

  // Follow the synchronised level only after it has differed for the full hold time.
  always_ff @(posedge hwclk) begin
    if (!reset_n) begin
      db_cnt_r    <= {DB_W{1'b0}};
      cpu_reset_n <= 1'b0;
    end else if (sync2_r == cpu_reset_n) begin
      db_cnt_r    <= {DB_W{1'b0}};
      cpu_reset_n <= cpu_reset_n;
    end else if (db_cnt_r == DB_LAST) begin
      db_cnt_r    <= {DB_W{1'b0}};
      cpu_reset_n <= sync2_r;
    end else begin
      db_cnt_r    <= db_cnt_r + DB_W'(1);
      cpu_reset_n <= cpu_reset_n;
    end
  end

endmodule

// File: rtl/z180_bus_strobe_sync.sv
// Z180 bus front end: debounced CPU reset and I/O read/write qualification ticks.
module z180_bus_strobe_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = z180_bus_pkg::DEBOUNCE_CYCLES_DEF,
  parameter int unsigned WR_TICK_EDGE    = z180_bus_pkg::WR_TICK_EDGE
) (
  input  logic hwclk,
  input  logic reset_n,
  input  logic phi_ce,
  input  logic sw_n,
  input  logic iorq_n,
  input  logic rd_n,
  input  logic wr_n,
  output logic cpu_reset_n,
  output logic iorq_rd_tick,
  output logic iorq_wr_tick
);

  logic fsm_rst_s;

  // The tick logic also sleeps while the CPU itself is held in reset.
  assign fsm_rst_s = ~reset_n | ~cpu_reset_n;

  switch_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .hwclk       (hwclk),
    .reset_n     (reset_n),
    .sw_n        (sw_n),
    .cpu_reset_n (cpu_reset_n)
  );

  iorq_tick_fsm #(
    .TICK_EDGE (z180_bus_pkg::RD_TICK_EDGE)
  ) u_rd_tick (
    .hwclk   (hwclk),
    .fsm_rst (fsm_rst_s),
    .phi_ce  (phi_ce),
    .iorq_n  (iorq_n),
    .dir_n   (rd_n),
    .tick    (iorq_rd_tick)
  );

  iorq_tick_fsm #(
    .TICK_EDGE (WR_TICK_EDGE)
  ) u_wr_tick (
    .hwclk   (hwclk),
    .fsm_rst (fsm_rst_s),
    .phi_ce  (phi_ce),
    .iorq_n  (iorq_n),
    .dir_n   (wr_n),
    .tick    (iorq_wr_tick)
  );

endmodule

// File: tb/tb_z180_bus_strobe_sync.sv
// Self-checking bench for z180_bus_strobe_sync against a behavioural reference model.
module tb_z180_bus_strobe_sync;

  localparam int DEB = 8;

  logic hwclk;
  logic reset_n;
  logic phi_ce;
  logic sw_n;
  logic iorq_n;
  logic rd_n;
  logic wr_n;
  logic cpu_reset_n;
  logic iorq_rd_tick;
  logic iorq_wr_tick;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit       m_out = 1'b0;
  bit [1:0] m_dly = 2'b11;
  bit       m_hist[$];
  int       m_rd_run = 0;
  int       m_wr_run = 0;

  // Observations of one bus cycle
  int obs_rd, obs_wr, rd_pos, wr_pos, mism;

  z180_bus_strobe_sync #(
    .DEBOUNCE_CYCLES (DEB),
    .WR_TICK_EDGE    (1)
  ) dut (
    .hwclk        (hwclk),
    .reset_n      (reset_n),
    .phi_ce       (phi_ce),
    .sw_n         (sw_n),
    .iorq_n       (iorq_n),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .cpu_reset_n  (cpu_reset_n),
    .iorq_rd_tick (iorq_rd_tick),
    .iorq_wr_tick (iorq_wr_tick)
  );

  initial begin
    hwclk = 1'b0;
    forever #5 hwclk = ~hwclk;
  end

  function automatic bit m_rst();
    return (reset_n !== 1'b1) || !m_out;
  endfunction

  // A tick is due on the phi fall whose 0-based position in the I/O cycle is the tick edge.
  function automatic bit exp_rd();
    return phi_ce && !iorq_n && !rd_n && (m_rd_run == 0) && !m_rst();
  endfunction

  function automatic bit exp_wr();
    return phi_ce && !iorq_n && !wr_n && (m_wr_run == 1) && !m_rst();
  endfunction

  // Advance one hwclk edge and update the model from the pre-edge inputs.
  task automatic step();
    bit rst_pre;
    bit lvl;
    int ones;
    @(posedge hwclk);
    rst_pre = m_rst();
    if (rst_pre) begin
      m_rd_run = 0;
      m_wr_run = 0;
    end else if (phi_ce) begin
      m_rd_run = (!iorq_n && !rd_n) ? m_rd_run + 1 : 0;
      m_wr_run = (!iorq_n && !wr_n) ? m_wr_run + 1 : 0;
    end
    if (!reset_n) begin
      m_dly = 2'b11;
      m_out = 1'b0;
      m_hist.delete();
    end else begin
      lvl   = m_dly[1];
      m_dly = {m_dly[0], sw_n};
      m_hist.push_back(lvl != m_out);
      if (m_hist.size() > DEB) void'(m_hist.pop_front());
      ones = 0;
      foreach (m_hist[i]) if (m_hist[i]) ones++;
      if (ones == DEB) begin
        m_out = lvl;
        m_hist.delete();
      end
    end
    #1;
  endtask

  task automatic cyc(input int p);
    #1;
    if (iorq_rd_tick !== exp_rd()) mism++;
    if (iorq_wr_tick !== exp_wr()) mism++;
    if (cpu_reset_n !== m_out) mism++;
    if (iorq_rd_tick === 1'b1) begin obs_rd++; rd_pos = p; end
    if (iorq_wr_tick === 1'b1) begin obs_wr++; wr_pos = p; end
    step();
  endtask

  // One bus cycle of nphi phi falls; optionally press the button after phi fall press_after.
  task automatic bus_cycle(input bit io, input bit rd, input bit wr, input int nphi,
                           input int period, input int press_after);
    obs_rd = 0; obs_wr = 0; rd_pos = 0; wr_pos = 0; mism = 0;
    iorq_n = !io; rd_n = !rd; wr_n = !wr; phi_ce = 1'b0;
    for (int p = 1; p <= nphi; p++) begin
      for (int k = 0; k < period - 1; k++) begin phi_ce = 1'b0; cyc(0); end
      phi_ce = 1'b1;
      cyc(p);
      phi_ce = 1'b0;
      if (p == press_after) sw_n = 1'b0;
    end
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    for (int k = 0; k < period - 1; k++) begin phi_ce = 1'b0; cyc(0); end
    phi_ce = 1'b1;
    cyc(0);
    phi_ce = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sw_n = 1'b1; phi_ce = 1'b1; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (cpu_reset_n !== 1'b0 || iorq_rd_tick !== 1'b0 || iorq_wr_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: cpu_reset_n=%b rd_tick=%b wr_tick=%b, required 0 0 0",
                 cpu_reset_n, iorq_rd_tick, iorq_wr_tick);
      end
      step();
    end
    phi_ce = 1'b0; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic test_power_up();
    int dut_rise;
    int model_rise;
    dut_rise = -1; model_rise = -1; mism = 0;
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      #1;
      if (cpu_reset_n !== m_out) mism++;
      if (dut_rise < 0 && cpu_reset_n === 1'b1) dut_rise = i;
      if (model_rise < 0 && m_out) model_rise = i;
    end
    checks++;
    if (dut_rise !== model_rise) begin
      errors++;
      $display("FAIL power_up_latency: released after %0d cycles, required %0d", dut_rise, model_rise);
    end
    checks++;
    if (mism !== 0 || cpu_reset_n !== 1'b1) begin
      errors++;
      $display("FAIL power_up_level: %0d cycle mismatches, final cpu_reset_n=%b, required 0 and 1",
               mism, cpu_reset_n);
    end
  endtask

  task automatic test_bounce();
    int fall_at;
    int highs;
    highs = 0; fall_at = -1;
    sw_n = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); if (cpu_reset_n === 1'b1) highs++; end
    sw_n = 1'b1;
    for (int i = 0; i < 12; i++) begin step(); if (cpu_reset_n === 1'b1) highs++; end
    checks++;
    if (highs !== 17) begin
      errors++;
      $display("FAIL bounce_short_pulse: cpu_reset_n high in %0d of 17 cycles, required 17", highs);
    end
    sw_n = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (fall_at < 0 && cpu_reset_n === 1'b0) fall_at = i;
    end
    checks++;
    if (fall_at !== 2 + DEB) begin
      errors++;
      $display("FAIL bounce_long_press: cpu_reset_n fell after %0d cycles, required %0d", fall_at, 2 + DEB);
    end
    sw_n = 1'b1;
    for (int i = 0; i < 2 + DEB + 2; i++) step();
    checks++;
    if (cpu_reset_n !== 1'b1) begin
      errors++;
      $display("FAIL bounce_release: cpu_reset_n=%b, required 1", cpu_reset_n);
    end
  endtask

  task automatic test_io_read();
    bus_cycle(1'b1, 1'b1, 1'b0, 3, 3, 0);
    checks++;
    if (obs_rd !== 1 || rd_pos !== 1) begin
      errors++;
      $display("FAIL io_read_tick: %0d ticks, last at phi %0d, required 1 at phi 1", obs_rd, rd_pos);
    end
    checks++;
    if (obs_wr !== 0 || mism !== 0) begin
      errors++;
      $display("FAIL io_read_other: wr ticks=%0d mismatches=%0d, required 0 and 0", obs_wr, mism);
    end
  endtask

  task automatic test_io_write_wait();
    bus_cycle(1'b1, 1'b0, 1'b1, 4, 3, 0);
    checks++;
    if (obs_wr !== 1 || wr_pos !== 2) begin
      errors++;
      $display("FAIL io_write_tick: %0d ticks, last at phi %0d, required 1 at phi 2", obs_wr, wr_pos);
    end
    checks++;
    if (obs_rd !== 0 || mism !== 0) begin
      errors++;
      $display("FAIL io_write_other: rd ticks=%0d mismatches=%0d, required 0 and 0", obs_rd, mism);
    end
  endtask

  task automatic test_mem_then_io();
    bus_cycle(1'b0, 1'b1, 1'b0, 3, 3, 0);
    checks++;
    if (obs_rd !== 0 || obs_wr !== 0 || mism !== 0) begin
      errors++;
      $display("FAIL mem_read_quiet: rd=%0d wr=%0d mismatches=%0d, required 0 0 0", obs_rd, obs_wr, mism);
    end
    bus_cycle(1'b1, 1'b1, 1'b0, 2, 3, 0);
    checks++;
    if (obs_rd !== 1 || rd_pos !== 1 || mism !== 0) begin
      errors++;
      $display("FAIL io_after_mem: %0d ticks at phi %0d, %0d mismatches, required 1 at phi 1, 0",
               obs_rd, rd_pos, mism);
    end
  endtask

  task automatic test_press_mid_write();
    bus_cycle(1'b1, 1'b0, 1'b1, 4, 12, 1);
    checks++;
    if (obs_wr !== 0 || mism !== 0 || cpu_reset_n !== 1'b0) begin
      errors++;
      $display("FAIL press_mid_write: wr ticks=%0d mismatches=%0d cpu_reset_n=%b, required 0 0 0",
               obs_wr, mism, cpu_reset_n);
    end
    sw_n = 1'b1;
    for (int i = 0; i < 2 + DEB + 2; i++) step();
    checks++;
    if (cpu_reset_n !== 1'b1) begin
      errors++;
      $display("FAIL press_release: cpu_reset_n=%b, required 1", cpu_reset_n);
    end
    bus_cycle(1'b1, 1'b0, 1'b1, 2, 3, 0);
    checks++;
    if (obs_wr !== 1 || wr_pos !== 2 || mism !== 0) begin
      errors++;
      $display("FAIL write_after_release: %0d ticks at phi %0d, %0d mismatches, required 1 at phi 2, 0",
               obs_wr, wr_pos, mism);
    end
  endtask

  task automatic test_random();
    bit io, rd, wr;
    int kind, nphi, period, e_rd, e_wr;
    for (int n = 0; n < 40; n++) begin
      io     = 1'($urandom_range(0, 1));
      kind   = int'($urandom_range(0, 2));
      rd     = (kind != 1);
      wr     = (kind != 0);
      nphi   = int'($urandom_range(1, 5));
      period = int'($urandom_range(2, 4));
      e_rd   = (io && rd) ? 1 : 0;
      e_wr   = (io && wr && nphi >= 2) ? 1 : 0;
      bus_cycle(io, rd, wr, nphi, period, 0);
      checks++;
      if (obs_rd !== e_rd || obs_wr !== e_wr || mism !== 0) begin
        errors++;
        $display("FAIL random_cycle_%0d: io=%b rd=%b wr=%b phis=%0d got rd=%0d wr=%0d mism=%0d, required rd=%0d wr=%0d mism=0",
                 n, io, rd, wr, nphi, obs_rd, obs_wr, mism, e_rd, e_wr);
      end
      checks++;
      if ((e_rd == 1 && rd_pos !== 1) || (e_wr == 1 && wr_pos !== 2)) begin
        errors++;
        $display("FAIL random_position_%0d: rd at phi %0d wr at phi %0d, required 1 and 2",
                 n, rd_pos, wr_pos);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; phi_ce = 1'b0; sw_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    test_reset();
    test_power_up();
    test_bounce();
    test_io_read();
    test_io_write_wait();
    test_mem_then_io();
    test_press_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/z180_bus_strobe_sync.md
# z180_bus_strobe_sync

Front-end conditioning block between the Z180 CPU bus and the FPGA peripherals (GPIO, VDP, joystick, boot-ROM disable). It debounces the reset push-button into the CPU reset line and generates single-cycle I/O read and write qualification ticks, aligned to CPU clock (phi) falling edges. Peripheral address decoders AND these ticks with their address match to get flip-flop clock enables.

## Interface
- DEBOUNCE_CYCLES, 250000: number of consecutive hwclk cycles the switch must hold a new level before the output follows (10 ms at 25 MHz).
- WR_TICK_EDGE, 1: phi falling-edge index (0-based) within an I/O write on which the write tick fires.
- hwclk  in  1  system clock; the only clock in the block.
- reset_n  in  1  synchronous, active-low block reset (clock hwclk).
- phi_ce  in  1  one-hwclk-cycle strobe marking each CPU phi falling edge; generated upstream.
- sw_n  in  1  raw reset push-button, active low, asynchronous.
- iorq_n, rd_n, wr_n  in  1 each  CPU bus strobes, active low. They are stable whenever phi_ce is high.
- cpu_reset_n  out  1  debounced button level, driven to the CPU /RESET.
- iorq_rd_tick  out  1  I/O read qualification pulse.
- iorq_wr_tick  out  1  I/O write qualification pulse.

## Operation
- Debounce:
  - sw_n passes through a 2-FF synchroniser.
  - A counter of width $clog2(DEBOUNCE_CYCLES+1) clears whenever the synchronised level equals cpu_reset_n.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, cpu_reset_n takes the new level and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Internal FSM reset: fsm_rst = ~reset_n | ~cpu_reset_n.
- Read counter rd_cnt (2 bits, saturating at 3):
  - Updates only on phi_ce.
  - If iorq_n=0 and rd_n=0, rd_cnt increments (saturating). Otherwise it returns to 0.
- Write counter wr_cnt: same rule, using wr_n instead of rd_n.
- iorq_rd_tick = phi_ce & ~iorq_n & ~rd_n & (rd_cnt==0) & ~fsm_rst. It fires on the first phi fall of the read, so read data is latched early.
- iorq_wr_tick = phi_ce & ~iorq_n & ~wr_n & (wr_cnt==WR_TICK_EDGE) & ~fsm_rst. It fires on the second phi fall, when write data is valid.
- Exactly one tick is issued per I/O cycle, however many wait states the cycle has.
- Memory cycles (iorq_n=1) never tick and hold the counters at 0.
- rd and wr asserted together (illegal on the bus): each counter and tick is evaluated independently. No arbitration.

## Timing
- Reset values:
  - cpu_reset_n=0, so the CPU is held in reset until the switch has been seen released for DEBOUNCE_CYCLES cycles. This doubles as a power-on reset.
  - Both counters 0; synchroniser FFs 1.
- Debounce latency: 2 sync cycles + DEBOUNCE_CYCLES cycles from a stable sw_n change to the cpu_reset_n change.
- Ticks are combinational (Mealy) from registered counters and bus inputs. Each is high for exactly the one hwclk cycle where phi_ce=1; consumers capture on that same edge.
- Counter update timing:
  - The counter changes on the hwclk edge ending a phi_ce cycle.
  - The tick uses the pre-update count.
  - A strobe deasserting between phi_ce pulses is seen at the next phi_ce, which clears the counter.
- Back-to-back I/O cycles: the counter must see one phi_ce with the strobe deasserted before a second tick can occur. This is guaranteed by the Z180 bus protocol.
- Mid-operation reset (reset_n low or cpu_reset_n low): counters clear on the next edge and ticks are forced low immediately. An I/O cycle still in progress when the reset releases produces no tick.

## Structure
- Shared package z180_bus_pkg:
  - CNT_W=2 counter width.
  - Default DEBOUNCE_CYCLES.
  - RD_TICK_EDGE=0 and WR_TICK_EDGE=1 constants.
- Sub-module switch_debounce: synchroniser, counter and output register.
- Sub-module iorq_tick_fsm with parameter TICK_EDGE, instantiated twice:
  - read instance: TICK_EDGE=0, direction strobe rd_n.
  - write instance: TICK_EDGE=1, direction strobe wr_n.
- Top z180_bus_strobe_sync contains only the instances and the fsm_rst logic.

## Test plan
- Power-up, DEBOUNCE_CYCLES=8: reset_n low for 3 cycles, then high with sw_n=1 -> cpu_reset_n stays 0 for 10 cycles, then goes 1 and stays 1.
- Bounce: with cpu_reset_n=1, pulse sw_n low for 5 cycles, then low for 12 cycles -> no change on the 5-cycle pulse; cpu_reset_n=0 exactly 10 cycles after the 12-cycle low begins.
- I/O read with 3 phi falls (iorq_n=rd_n=0) -> iorq_rd_tick high only on phi_ce #1; iorq_wr_tick never high.
- I/O write with 4 phi falls (one wait state) -> iorq_wr_tick high only on phi_ce #2; exactly one pulse.
- Memory read (iorq_n=1, rd_n=0) then I/O read -> no tick during the memory read; the I/O read ticks on its first phi_ce.
- Button pressed mid-write after phi_ce #1 -> no write tick. After release and debounce, the next I/O write ticks normally on its phi_ce #2.
